sha256_core: RTL and testbench
==============================

SHA256_CORE -- requirements
Module: sha256_core

Interface
REQ-001 SHALL have parameter BlockWidth, default 512, message block width in bits (only 512 supported).
REQ-002 SHALL have parameter DigestWidth, default 256, digest output width.
REQ-003 SHALL have parameter Sha224Enable, default 1; when 0, mode_i is ignored and SHA-256 is always used.
REQ-004 SHALL have port clk_i  input  1  clock.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port block_i  input  BlockWidth  message block, big-endian, word 0 in bits [511:480].
REQ-007 SHALL have port block_valid_i  input  1  block_i valid.
REQ-008 SHALL have port block_ready_o  output  1  core can accept block_i.
REQ-009 SHALL have port last_block_i  input  1  qualifies the accepted block as final; sampled at handshake.
REQ-010 SHALL have port mode_i  input  1  0=SHA-256, 1=SHA-224; sampled at the first handshake only.
REQ-011 SHALL have port enable_hash_i  input  1  run enable; low pauses rounds.
REQ-012 SHALL have port rst_hash_i  input  1  synchronous hash abort/restart.
REQ-013 SHALL have port hold_o  output  1  core is in HOLD.
REQ-014 SHALL have port idle_o  output  1  core is in IDLE.
REQ-015 SHALL have port digest_o  output  DigestWidth  H0..H7 concatenated, H0 in the MSBs.
REQ-016 SHALL have port digest_valid_o  output  1  digest_o is final.

Function
REQ-017 SHALL implement states IDLE, HASHING, FINAL, HOLD and DONE.
REQ-018 SHALL assert block_ready_o = enable_hash_i & ~rst_hash_i in IDLE and HOLD, and 0 in all other states.
REQ-019 On handshake (block_valid_i & block_ready_o) in IDLE, the core SHALL load the H and a..h registers with the IV of the sampled mode, latch the block, mode and last flag, and go to HASHING.
REQ-020 On handshake in HOLD, the core SHALL load a..h from the current H, latch the block and last flag, keep the latched mode, and go to HASHING.
REQ-021 HASHING SHALL perform one SHA-2 round per cycle for rounds 0..63, using W[t] = block words for t<16 and the sigma0/sigma1 recurrence over a 16-word rolling window for t>=16.
REQ-022 After round 63 the core SHALL enter FINAL for one cycle: Hi <= Hi + working variable (mod 2^32), then go to DONE if the latched last flag is set, else HOLD.
REQ-023 With enable_hash_i low in HASHING, the core SHALL freeze the round counter, window and a..h, and stay in HASHING; the pause SHALL NOT change the result.
REQ-024 rst_hash_i high in any state SHALL force IDLE next cycle, clear digest_valid_o and drop the block in progress; it SHALL take precedence over a simultaneous handshake.
REQ-025 Latency: with enable_hash_i held high, digest_valid_o SHALL rise 66 cycles after the accepting clock edge of a final block.
REQ-026 DONE SHALL hold digest_valid_o=1 and a stable digest_o until rst_hash_i; block_valid_i SHALL be ignored in DONE.
REQ-027 In SHA-224 mode, digest_o[255:32] SHALL carry H0..H6 and digest_o[31:0] SHALL be zero.
REQ-028 digest_o SHALL show the running H registers in HOLD and DONE, and zero in IDLE.
REQ-029 hold_o and idle_o SHALL be registered state decodes, not next-state.

Reset
REQ-030 On rst_ni low, the core SHALL enter IDLE with round counter 0, window 0, H and a..h set to the SHA-256 IV, and outputs block_ready_o=0, hold_o=0, idle_o=1, digest_o=0, digest_valid_o=0.

Structure
REQ-031 Package sha2_pkg SHALL hold the 64-entry K table, the SHA-256 and SHA-224 IVs, the state enum and the Sigma/sigma/Ch/Maj functions.
REQ-032 The message-schedule window SHALL be a sub-module named sha256_schedule (load, advance, W[t] out).

Verification
REQ-033 The bench SHALL cover: "abc" padded single block, mode 0 -> digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, valid at +66 cycles.
REQ-034 The bench SHALL cover: "abc" single block, mode 1 -> digest_o[255:32]=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, [31:0]=0.
REQ-035 The bench SHALL cover: the 56-byte "abcdbcdecdefdefg...nopq" message as two blocks (first with last=0, HOLD in between) -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-036 The bench SHALL cover: the "abc" case with enable_hash_i low for 5 cycles at round 20 -> same digest, valid at +71 cycles.
REQ-037 The bench SHALL cover: rst_hash_i pulsed at round 30, then "abc" re-sent -> idle_o=1 next cycle, no stale valid, correct "abc" digest.
REQ-038 The bench SHALL cover: rst_ni asserted mid-hash -> all outputs at reset values immediately, with block_valid_i ignored in DONE.

Source files
------------

// File: rtl/sha2_pkg.sv
// SHA-2 (256/224) shared definitions.
// Contents: FSM state enum, round constant table K, the SHA-256 and SHA-224
// initial hash values, and the round/schedule mixing functions.
`timescale 1ns/1ps
package sha2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HASHING = 3'd1,
        ST_FINAL   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DONE    = 3'd4
    } sha2_state_e;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV_SHA256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] IV_SHA224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return ror32(x, 2) ^ ror32(x, 13) ^ ror32(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return ror32(x, 6) ^ ror32(x, 11) ^ ror32(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, f, g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, b, c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_schedule.sv
// SHA-256 message schedule: a 16-word rolling window.
// Ports: clk_i, rst_ni (async active-low); load_i copies block_i (word 0 in
// [511:480]) into the window; advance_i shifts the window by one word and
// appends the next recurrence word; w_o is W[t] for the current round.
`timescale 1ns/1ps
module sha256_schedule
    import sha2_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         advance_i,
    input  logic [511:0] block_i,
    output logic [31:0]  w_o
);

    logic [31:0] w_q [16];
    logic [31:0] w_next;

    // With w_q[0] = W[t]: W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
    // Running it from round 0 keeps the window correct for every t.
    assign w_next = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
    assign w_o    = w_q[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else if (load_i) begin
            for (int i = 0; i < 16; i++) w_q[i] <= block_i[511 - 32*i -: 32];
        end else if (advance_i) begin
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
            w_q[15] <= w_next;
        end
    end

endmodule

// File: rtl/sha256_core.sv
// Iterative SHA-256/SHA-224 core, one round per clock.
// Ports: clk_i, rst_ni (async active-low); block_i/block_valid_i/block_ready_o
// with last_block_i and mode_i (0=SHA-256, 1=SHA-224) qualify input blocks;
// enable_hash_i pauses rounds; rst_hash_i aborts to IDLE; hold_o/idle_o are
// state decodes; digest_o (H0 in MSBs) is final while digest_valid_o is high.
`timescale 1ns/1ps
module sha256_core
    import sha2_pkg::*;
#(
    parameter int BlockWidth   = 512,
    parameter int DigestWidth  = 256,
    parameter bit Sha224Enable = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [BlockWidth-1:0]  block_i,
    input  logic                   block_valid_i,
    output logic                   block_ready_o,
    input  logic                   last_block_i,
    input  logic                   mode_i,
    input  logic                   enable_hash_i,
    input  logic                   rst_hash_i,
    output logic                   hold_o,
    output logic                   idle_o,
    output logic [DigestWidth-1:0] digest_o,
    output logic                   digest_valid_o
);

    sha2_state_e state_q, state_d;
    logic [5:0]  round_q;
    logic        mode_q, last_q, digest_valid_q;
    logic [31:0] h_q  [8];
    logic [31:0] wv_q [8];   // working variables a..h
    logic [31:0] wv_d [8];
    logic [31:0] iv_sel [8];
    logic [31:0] w_t, t1, t2;
    logic        mode_sel;
    logic        load_iv, load_h, do_round, do_final;
    logic [255:0] digest_full;

    assign mode_sel = Sha224Enable & mode_i;

    always_comb begin
        for (int i = 0; i < 8; i++) iv_sel[i] = mode_sel ? IV_SHA224[i] : IV_SHA256[i];
    end

    sha256_schedule u_schedule (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (load_iv | load_h),
        .advance_i (do_round),
        .block_i   (block_i),
        .w_o       (w_t)
    );

    // Compression round on a..h = wv_q[0..7].
    assign t1 = wv_q[7] + big_sigma1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6]) + K[round_q] + w_t;
    assign t2 = big_sigma0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);

    always_comb begin
        wv_d[0] = t1 + t2;
        wv_d[1] = wv_q[0];
        wv_d[2] = wv_q[1];
        wv_d[3] = wv_q[2];
        wv_d[4] = wv_q[3] + t1;
        wv_d[5] = wv_q[4];
        wv_d[6] = wv_q[5];
        wv_d[7] = wv_q[6];
    end

    // Handshake: a block transfers on a rising clk_i edge where block_valid_i
    // and block_ready_o are both high. Ready is offered only in IDLE and HOLD,
    // only while enable_hash_i is high and rst_hash_i is low, and never while
    // rst_ni is asserted; the producer holds block_i/last_block_i/mode_i
    // stable while block_valid_i is high.
    always_comb begin
        state_d       = state_q;
        block_ready_o = 1'b0;
        load_iv       = 1'b0;
        load_h        = 1'b0;
        do_round      = 1'b0;
        do_final      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_HOLD: begin
                block_ready_o = rst_ni & enable_hash_i & ~rst_hash_i;
                if (block_valid_i && rst_ni && enable_hash_i && !rst_hash_i) begin
                    state_d = ST_HASHING;
                    load_iv = (state_q == ST_IDLE);
                    load_h  = (state_q == ST_HOLD);
                end
            end
            ST_HASHING: begin
                if (enable_hash_i) begin
                    do_round = 1'b1;
                    if (round_q == 6'd63) state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                do_final = 1'b1;
                state_d  = last_q ? ST_DONE : ST_HOLD;
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over everything, including a simultaneous handshake.
        if (rst_hash_i) begin
            state_d  = ST_IDLE;
            load_iv  = 1'b0;
            load_h   = 1'b0;
            do_round = 1'b0;
            do_final = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            round_q        <= '0;
            mode_q         <= 1'b0;
            last_q         <= 1'b0;
            digest_valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= IV_SHA256[i];
                wv_q[i] <= IV_SHA256[i];
            end
        end else begin
            // Valid trails entry into DONE by one cycle, giving the 66-cycle
            // accept-to-valid latency.
            digest_valid_q <= (state_q == ST_DONE) && !rst_hash_i;
            if (load_iv) begin
                round_q <= '0;
                mode_q  <= mode_sel;
                last_q  <= last_block_i;
                for (int i = 0; i < 8; i++) begin
                    h_q[i]  <= iv_sel[i];
                    wv_q[i] <= iv_sel[i];
                end
            end else if (load_h) begin
                round_q <= '0;
                last_q  <= last_block_i;
                for (int i = 0; i < 8; i++) wv_q[i] <= h_q[i];
            end else if (do_round) begin
                round_q <= round_q + 6'd1;
                for (int i = 0; i < 8; i++) wv_q[i] <= wv_d[i];
            end else if (do_final) begin
                for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + wv_q[i];
            end
        end
    end

    always_comb begin
        digest_full = '0;
        if (state_q == ST_HOLD || state_q == ST_DONE) begin
            for (int i = 0; i < 8; i++) digest_full[255 - 32*i -: 32] = h_q[i];
            if (mode_q) digest_full[31:0] = '0;
        end
    end

    assign digest_o       = digest_full[DigestWidth-1:0];
    assign digest_valid_o = digest_valid_q;
    assign hold_o         = (state_q == ST_HOLD);
    assign idle_o         = (state_q == ST_IDLE);

endmodule

// File: tb/tb_sha256_core.sv
`timescale 1ns/1ps
module tb_sha256_core;

  localparam int PERIOD = 10;

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] TWO_B1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2  = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] ABC_256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ABC_224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
  localparam logic [255:0] TWO_256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst_ni;
  logic [511:0] block_i;
  logic         block_valid_i, block_ready_o, last_block_i, mode_i;
  logic         enable_hash_i, rst_hash_i, hold_o, idle_o, digest_valid_o;
  logic [255:0] digest_o;

  always #(PERIOD/2) clk = ~clk;

  sha256_core #(.BlockWidth(512), .DigestWidth(256), .Sha224Enable(1'b1)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .block_i        (block_i),
    .block_valid_i  (block_valid_i),
    .block_ready_o  (block_ready_o),
    .last_block_i   (last_block_i),
    .mode_i         (mode_i),
    .enable_hash_i  (enable_hash_i),
    .rst_hash_i     (rst_hash_i),
    .hold_o         (hold_o),
    .idle_o         (idle_o),
    .digest_o       (digest_o),
    .digest_valid_o (digest_valid_o)
  );

  // scoreboard
  int           tests_run = 0;
  int           tests_failed = 0;
  logic [255:0] exp_q[$];
  int           lat_q[$];
  time          accept_t = 0;
  logic         seen_valid = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: one comparison per rising edge of digest_valid_o
  always @(negedge clk) begin
    if (!rst_ni) begin
      seen_valid = 1'b0;
    end else if (digest_valid_o && !seen_valid) begin
      seen_valid = 1'b1;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_valid: got digest %h with nothing expected", digest_o);
      end else begin
        int lat;
        lat = int'(($time - accept_t - PERIOD/2) / PERIOD);
        check("digest", digest_o, exp_q.pop_front());
        check("latency", 256'(lat), 256'(lat_q.pop_front()));
      end
    end else if (!digest_valid_o) begin
      seen_valid = 1'b0;
    end
  end

  // driver tasks
  task automatic send_block(input logic [511:0] blk, input logic last, input logic mode);
    int n;
    @(negedge clk);
    block_i = blk;
    last_block_i = last;
    mode_i = mode;
    block_valid_i = 1'b1;
    n = 0;
    while (!block_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!block_ready_o) begin
      tests_run++;
      tests_failed++;
      $display("FAIL ready_timeout: got block_ready_o=0 required 1");
    end
    @(posedge clk);
    if (last) accept_t = $time;
    #1 block_valid_i = 1'b0;
  endtask

  task automatic expect_digest(input logic [255:0] d, input int lat);
    exp_q.push_back(d);
    lat_q.push_back(lat);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 256'(exp_q.size()), 256'd0);
    exp_q.delete();
    lat_q.delete();
  endtask

  task automatic hash_restart();
    @(posedge clk);
    #1 rst_hash_i = 1'b1;
    @(posedge clk);
    #1 rst_hash_i = 1'b0;
    @(negedge clk);
    check("restart_idle", 256'(idle_o), 256'd1);
    check("restart_valid", 256'(digest_valid_o), 256'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {251'd0, block_ready_o, hold_o, idle_o, digest_valid_o, 1'b0}, {251'd0, 5'b00100});
    check("reset_digest", digest_o, 256'd0);
  endtask

  initial begin
    rst_ni = 1'b0;
    block_i = '0;
    block_valid_i = 1'b0;
    last_block_i = 1'b0;
    mode_i = 1'b0;
    enable_hash_i = 1'b1;
    rst_hash_i = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_outputs");
    @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check("idle_ready", 256'(block_ready_o), 256'd1);

    // "abc" SHA-256, then block_valid_i held in DONE
    expect_digest(ABC_256, 66);
    send_block(ABC_BLK, 1'b1, 1'b0);
    wait_drain("drain_abc256");
    block_i = TWO_B1;
    block_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("done_ready", 256'(block_ready_o), 256'd0);
    end
    check("done_stable", digest_o, ABC_256);
    check("done_valid", 256'(digest_valid_o), 256'd1);
    block_valid_i = 1'b0;
    hash_restart();
    check("idle_digest", digest_o, 256'd0);

    // "abc" SHA-224
    expect_digest(ABC_224, 66);
    send_block(ABC_BLK, 1'b1, 1'b1);
    wait_drain("drain_abc224");
    hash_restart();

    // two-block message; mode_i=1 on the second block must be ignored
    send_block(TWO_B1, 1'b0, 1'b0);
    begin
      int n;
      n = 0;
      while (!hold_o && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("hold_state", 256'(hold_o), 256'd1);
    check("hold_valid", 256'(digest_valid_o), 256'd0);
    check("hold_ready", 256'(block_ready_o), 256'd1);
    expect_digest(TWO_256, 66);
    send_block(TWO_B2, 1'b1, 1'b1);
    wait_drain("drain_two_block");
    hash_restart();

    // five-cycle pause at round 20
    expect_digest(ABC_256, 71);
    send_block(ABC_BLK, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1 enable_hash_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 enable_hash_i = 1'b1;
    wait_drain("drain_pause");
    hash_restart();

    // abort at round 30, then resend
    send_block(ABC_BLK, 1'b1, 1'b0);
    repeat (30) @(posedge clk);
    #1 rst_hash_i = 1'b1;
    @(negedge clk);
    check("abort_ready", 256'(block_ready_o), 256'd0);
    @(posedge clk);
    #1 rst_hash_i = 1'b0;
    @(negedge clk);
    check("abort_idle", 256'(idle_o), 256'd1);
    repeat (60) @(negedge clk);
    check("abort_no_valid", 256'(digest_valid_o), 256'd0);
    expect_digest(ABC_256, 66);
    send_block(ABC_BLK, 1'b1, 1'b0);
    wait_drain("drain_resend");

    // rst_ni in DONE, then mid-hash
    @(posedge clk);
    #3 rst_ni = 1'b0;
    #1 check_reset_outputs("rst_in_done");
    @(posedge clk);
    #1 rst_ni = 1'b1;
    send_block(ABC_BLK, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #3 rst_ni = 1'b0;
    #1 check_reset_outputs("rst_mid_hash");
    @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (80) @(negedge clk);
    check("post_reset_no_valid", 256'(digest_valid_o), 256'd0);
    check("post_reset_idle", 256'(idle_o), 256'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    tests_failed++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1);
  end

endmodule
